// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I sequencer for a shared PC/IR/ALU/memory datapath.
// Build option: define PERF_COUNTERS_EN to add the cycleCount/instCount counters.
// Without it both counter outputs are tied to zero.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        memReady,
  input  logic        branchTaken,
  output logic        memReq,
  output logic        memWrite,
  output logic        iOrD,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic        regWrite,
  output logic        memToReg,
  output logic [2:0]  state,
  output logic        instRetired,
  output logic        halted,
  output logic        illegal,
  output logic        busError,
  output logic [31:0] cycleCount,
  output logic [31:0] instCount
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMACC    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_TRAP      = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_error_q, bus_error_d;
  logic             inst_retired;

  logic [6:0] opcode;
  logic       is_load, is_store, is_branch, is_opimm, is_op, is_system;
  logic       timeout_hit;
  logic       unused_instr;

  assign opcode       = instruction[6:0];
  assign unused_instr = ^instruction[31:7];
  assign is_load      = (opcode == OPC_LOAD);
  assign is_store     = (opcode == OPC_STORE);
  assign is_branch    = (opcode == OPC_BRANCH);
  assign is_opimm     = (opcode == OPC_OPIMM);
  assign is_op        = (opcode == OPC_OP);
  assign is_system    = (opcode == OPC_SYSTEM);

  // memReady on the last allowed edge still wins, so the timeout is only taken without it
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !memReady && (wait_cnt_q == WAIT_LAST);

  // Next-state, wait counter and sticky fault flags
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    unique case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        wait_cnt_d = '0;
      end
      S_FETCH, S_MEMACC: begin
        if (memReady) begin
          wait_cnt_d = '0;
          if (state_q == S_FETCH)   state_d = S_DECODE;
          else if (is_store)        state_d = S_FETCH;
          else                      state_d = S_WRITEBACK;
        end else if (timeout_hit) begin
          state_d     = S_TRAP;
          bus_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (is_system) begin
          state_d = S_HALT;
        end else if (is_load || is_store || is_branch || is_opimm || is_op) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        wait_cnt_d = '0;
        if (is_load || is_store) begin
          state_d = S_MEMACC;
        end else if (is_branch) begin
          state_d = S_FETCH;
        end else if (is_opimm || is_op) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_WRITEBACK: begin
        state_d    = S_FETCH;
        wait_cnt_d = '0;
      end
      default: state_d = state_q;
    endcase
  end

  // Sequencer state and fault flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Datapath control decoded from the current state
  always_comb begin
    memReq       = 1'b0;
    memWrite     = 1'b0;
    iOrD         = 1'b0;
    irWrite      = 1'b0;
    pcWrite      = 1'b0;
    pcSrc        = 1'b0;
    aluSrcA      = 2'b00;
    aluSrcB      = 2'b00;
    aluOp        = 2'b00;
    regWrite     = 1'b0;
    memToReg     = 1'b0;
    inst_retired = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memReq  = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
      end
      S_EXECUTE: begin
        aluSrcA = 2'b10;
        if (is_load || is_store) begin
          aluSrcB = 2'b10;
        end else if (is_opimm) begin
          aluSrcB = 2'b10;
          aluOp   = 2'b10;
        end else if (is_op) begin
          aluOp   = 2'b10;
        end else if (is_branch) begin
          aluOp        = 2'b01;
          pcSrc        = 1'b1;
          pcWrite      = branchTaken;
          inst_retired = 1'b1;
        end
      end
      S_MEMACC: begin
        memReq       = 1'b1;
        iOrD         = 1'b1;
        memWrite     = is_store;
        inst_retired = is_store && memReady;
      end
      S_WRITEBACK: begin
        regWrite     = 1'b1;
        memToReg     = is_load;
        inst_retired = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instRetired = inst_retired;
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;
  assign busError    = bus_error_q;

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] inst_count_q, inst_count_d;

  // Cycle counter saturates; retired counter wraps
  always_comb begin
    cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 32'd1;
    inst_count_d  = inst_count_q + {31'd0, inst_retired};
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
      inst_count_q  <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      inst_count_q  <= inst_count_d;
    end
  end

  assign cycleCount = cycle_count_q;
  assign instCount  = inst_count_q;
`else
  assign cycleCount = '0;
  assign instCount  = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected state/control vectors go into a
// scoreboard queue as stimulus is driven and are compared against the DUT outputs.
module tb_multicycle_control;

  localparam logic [31:0] I_ADD   = 32'h003100B3;
  localparam logic [31:0] I_LW    = 32'h0000A083;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_ADDI  = 32'h00108093;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        memReady, branchTaken;
  logic        memReq, memWrite, iOrD, irWrite, pcWrite, pcSrc;
  logic [1:0]  aluSrcA, aluSrcB, aluOp;
  logic        regWrite, memToReg, instRetired, halted, illegal, busError;
  logic [2:0]  state;
  logic [31:0] cycleCount, instCount;
  logic [20:0] obs;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [20:0] exp_q[$];

  multicycle_control #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .memReady(memReady),
    .branchTaken(branchTaken), .memReq(memReq), .memWrite(memWrite), .iOrD(iOrD),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .regWrite(regWrite), .memToReg(memToReg),
    .state(state), .instRetired(instRetired), .halted(halted), .illegal(illegal),
    .busError(busError), .cycleCount(cycleCount), .instCount(instCount)
  );

  always #5 clk = ~clk;

  assign obs = {state, memReq, memWrite, iOrD, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
                aluOp, regWrite, memToReg, instRetired, halted, illegal, busError};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [20:0] vec(input logic [2:0] st, input logic mreq, input logic mwr,
      input logic iord, input logic irw, input logic pcw, input logic pcs, input logic [1:0] a,
      input logic [1:0] b, input logic [1:0] op, input logic rw, input logic m2r,
      input logic ret, input logic hlt, input logic ill, input logic berr);
    return {st, mreq, mwr, iord, irw, pcw, pcs, a, b, op, rw, m2r, ret, hlt, ill, berr};
  endfunction

  function automatic logic [20:0] e_idle();
    return vec(3'd0, 0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0,0,0);
  endfunction
  function automatic logic [20:0] e_fetch(input logic mr);
    return vec(3'd1, 1,0,0,mr,mr,0, 2'b00,2'b01,2'b00, 0,0,0,0,0,0);
  endfunction
  function automatic logic [20:0] e_decode();
    return vec(3'd2, 0,0,0,0,0,0, 2'b01,2'b10,2'b00, 0,0,0,0,0,0);
  endfunction
  function automatic logic [20:0] e_ex_r();
    return vec(3'd3, 0,0,0,0,0,0, 2'b10,2'b00,2'b10, 0,0,0,0,0,0);
  endfunction
  function automatic logic [20:0] e_ex_i();
    return vec(3'd3, 0,0,0,0,0,0, 2'b10,2'b10,2'b10, 0,0,0,0,0,0);
  endfunction
  function automatic logic [20:0] e_ex_ls();
    return vec(3'd3, 0,0,0,0,0,0, 2'b10,2'b10,2'b00, 0,0,0,0,0,0);
  endfunction
  function automatic logic [20:0] e_ex_br(input logic bt);
    return vec(3'd3, 0,0,0,0,bt,1, 2'b10,2'b00,2'b01, 0,0,1,0,0,0);
  endfunction
  function automatic logic [20:0] e_mem(input logic st, input logic mr);
    return vec(3'd4, 1,st,1,0,0,0, 2'b00,2'b00,2'b00, 0,0,st & mr,0,0,0);
  endfunction
  function automatic logic [20:0] e_wb(input logic ld);
    return vec(3'd5, 0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,ld,1,0,0,0);
  endfunction
  function automatic logic [20:0] e_halt();
    return vec(3'd6, 0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,1,0,0);
  endfunction
  function automatic logic [20:0] e_trap(input logic ill, input logic berr);
    return vec(3'd7, 0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0,ill,berr);
  endfunction

  // Called at a falling edge: drive one cycle, queue its expectation, compare, advance.
  task automatic step(input string tag, input logic [31:0] ins, input logic mr,
                      input logic bt, input logic [20:0] exp);
    logic [20:0] e;
    instruction = ins;
    memReady    = mr;
    branchTaken = bt;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, {11'd0, obs}, {11'd0, e});
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at a falling edge with reset released, DUT in IDLE.
  task automatic apply_reset(input string tag);
    rst_n    = 1'b0;
    memReady = 1'b0;
    #1;
    check_eq(tag, {11'd0, obs}, {11'd0, e_idle()});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; instruction = I_ADD; memReady = 1'b0; branchTaken = 1'b0;
    @(negedge clk);
    apply_reset("reset");

    // add, lw with waits, sw, addi, beq taken/not taken, fetch waits, ecall
    step("idle", I_ADD, 1, 0, e_idle());
    step("add_fetch", I_ADD, 1, 0, e_fetch(1));
    step("add_decode", I_ADD, 1, 0, e_decode());
    step("add_exec", I_ADD, 1, 0, e_ex_r());
    step("add_wb", I_ADD, 1, 0, e_wb(0));
    step("lw_fetch", I_ADD, 1, 0, e_fetch(1));
    step("lw_decode", I_LW, 1, 0, e_decode());
    step("lw_exec", I_LW, 1, 0, e_ex_ls());
    for (int i = 0; i < 3; i++) step("lw_mem_wait", I_LW, 0, 0, e_mem(0, 0));
    step("lw_mem_done", I_LW, 1, 0, e_mem(0, 1));
    step("lw_wb", I_LW, 1, 0, e_wb(1));
    step("sw_fetch", I_LW, 1, 0, e_fetch(1));
    step("sw_decode", I_SW, 1, 0, e_decode());
    step("sw_exec", I_SW, 1, 0, e_ex_ls());
    step("sw_mem", I_SW, 1, 0, e_mem(1, 1));
    step("addi_fetch", I_SW, 1, 0, e_fetch(1));
    step("addi_decode", I_ADDI, 1, 0, e_decode());
    step("addi_exec", I_ADDI, 1, 0, e_ex_i());
    step("addi_wb", I_ADDI, 1, 0, e_wb(0));
    step("beqt_fetch", I_ADDI, 1, 0, e_fetch(1));
    step("beqt_decode", I_BEQ, 1, 1, e_decode());
    step("beqt_exec", I_BEQ, 1, 1, e_ex_br(1));
    step("beqn_fetch", I_BEQ, 1, 0, e_fetch(1));
    step("beqn_decode", I_BEQ, 1, 0, e_decode());
    step("beqn_exec", I_BEQ, 1, 0, e_ex_br(0));
    step("fetch_wait", I_BEQ, 0, 0, e_fetch(0));
    step("fetch_wait", I_BEQ, 0, 0, e_fetch(0));
    step("ecall_fetch", I_BEQ, 1, 0, e_fetch(1));
    step("ecall_decode", I_ECALL, 1, 0, e_decode());
    for (int i = 0; i < 3; i++) step("halt", I_ECALL, 1, 1, e_halt());

    // asynchronous reset in the middle of a load access
    apply_reset("reset_from_halt");
    step("idle2", I_LW, 1, 0, e_idle());
    step("lw2_fetch", I_LW, 1, 0, e_fetch(1));
    step("lw2_decode", I_LW, 1, 0, e_decode());
    step("lw2_exec", I_LW, 1, 0, e_ex_ls());
    memReady = 1'b0;
    #3;
    check_eq("lw2_mem", {11'd0, obs}, {11'd0, e_mem(0, 0)});
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_mem", {11'd0, obs}, {11'd0, e_idle()});
    @(negedge clk);
    rst_n = 1'b1;
    step("idle3", I_LW, 1, 0, e_idle());
    step("fetch_after_reset", I_LW, 1, 0, e_fetch(1));

    // illegal opcode parks in TRAP
    apply_reset("reset_before_illegal");
    step("idle4", I_BAD, 1, 0, e_idle());
    step("bad_fetch", I_BAD, 1, 0, e_fetch(1));
    step("bad_decode", I_BAD, 1, 0, e_decode());
    for (int i = 0; i < 2; i++) step("trap_illegal", I_BAD, 1, 0, e_trap(1, 0));

    // fetch timeout after 16 cycles without memReady
    apply_reset("reset_clears_illegal");
    step("idle5", I_ADD, 0, 0, e_idle());
    for (int i = 0; i < 16; i++) step("to_fetch_wait", I_ADD, 0, 0, e_fetch(0));
    for (int i = 0; i < 2; i++) step("trap_bus", I_ADD, 1, 0, e_trap(0, 1));

    // memReady on the last allowed cycle wins over the timeout
    apply_reset("reset_clears_bus");
    step("idle6", I_ADD, 0, 0, e_idle());
    for (int i = 0; i < 15; i++) step("edge_fetch_wait", I_ADD, 0, 0, e_fetch(0));
    step("edge_fetch_ready", I_ADD, 1, 0, e_fetch(1));
    step("edge_decode", I_ADD, 1, 0, e_decode());

    // store timeout in MEMACC
    apply_reset("reset_before_mem_to");
    step("idle7", I_SW, 1, 0, e_idle());
    step("swto_fetch", I_SW, 1, 0, e_fetch(1));
    step("swto_decode", I_SW, 1, 0, e_decode());
    step("swto_exec", I_SW, 1, 0, e_ex_ls());
    for (int i = 0; i < 16; i++) step("swto_mem_wait", I_SW, 0, 0, e_mem(1, 0));
    step("trap_bus_mem", I_SW, 0, 0, e_trap(0, 1));

    // ten back-to-back R-type instructions, then the counters
    apply_reset("reset_before_perf");
    step("idle8", I_ADD, 1, 0, e_idle());
    for (int i = 0; i < 10; i++) begin
      step("perf_fetch", I_ADD, 1, 0, e_fetch(1));
      step("perf_decode", I_ADD, 1, 0, e_decode());
      step("perf_exec", I_ADD, 1, 0, e_ex_r());
      step("perf_wb", I_ADD, 1, 0, e_wb(0));
    end
    #1;
`ifdef PERF_COUNTERS_EN
    check_eq("cycleCount", cycleCount, 32'd41);
    check_eq("instCount", instCount, 32'd10);
`else
    check_eq("cycleCount", cycleCount, 32'd0);
    check_eq("instCount", instCount, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
